// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer: exceptions, MRET and interrupts
//
// Sequences a trap or MRET as IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE.
// The pipeline is stalled for the whole sequence; the CSR file is written
// once in WRITE and the fetch unit is redirected in REDIRECT.
//
// Build option: define TRAP_CTRL_IRQ_EN to enable interrupt qualification,
// vectoring and the mip_o mirror. Without it only exceptions and MRET are
// handled, irq_* lines are ignored and mip_o is tied to 0.
//
// Parameter
//   VECTORED          1 enables vectored interrupt entry (mtvec[1:0]==01)
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   exc_*             exception request, cause code, faulting pc, tval
//   mret_i            MRET retiring
//   next_pc_i         pc of next unretired instruction (interrupt mepc)
//   irq_*_i           level interrupt lines (ext/sw/timer)
//   csr_*_i           current CSR values; csr_mtvec_i carries mepc while aux_o=1
//   we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o, aux_o   CSR trap write bus
//   stall_o, flush_o  pipeline control
//   redirect_*        fetch redirect handshake
//   mip_o             pending-interrupt mirror
module trap_ctrl #(
   parameter int VECTORED = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        exc_valid_i,
   input  logic [3:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic [31:0] exc_tval_i,
   input  logic        mret_i,
   input  logic [31:0] next_pc_i,
   input  logic        irq_ext_i,
   input  logic        irq_sw_i,
   input  logic        irq_timer_i,
   input  logic [31:0] csr_mstatus_i,
   input  logic [31:0] csr_mie_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mcause_i,
   input  logic [31:0] csr_mtval_i,
   input  logic [31:0] csr_mtvec_i,
   output logic        we_exc_o,
   output logic [31:0] mcause_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mtval_o,
   output logic [31:0] mstatus_o,
   output logic        aux_o,
   output logic        stall_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        redirect_ready_i,
   output logic [31:0] mip_o
);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WRITE, S_REDIRECT} state_t;

   state_t      state, state_nxt;
   logic        lat_irq, lat_mret;
   logic [3:0]  lat_code;
   logic [31:0] lat_pc, lat_tval;
   logic        irq_take;
   logic [3:0]  irq_code;
   logic [31:0] mtvec_base;

   // Keeps lint quiet about CSR/irq bits that only some builds look at.
   logic unused_ok;
   assign unused_ok = ^{csr_mie_i, irq_ext_i, irq_sw_i, irq_timer_i, next_pc_i};

`ifdef TRAP_CTRL_IRQ_EN
   logic [31:0] mip_q;

   // Fixed priority ext > sw > timer, all gated by global MIE.
   always_comb begin
      irq_take = 1'b0;
      irq_code = 4'd0;
      if (csr_mstatus_i[3]) begin
         if (csr_mie_i[11] && irq_ext_i) begin
            irq_take = 1'b1;
            irq_code = 4'd11;
         end else if (csr_mie_i[3] && irq_sw_i) begin
            irq_take = 1'b1;
            irq_code = 4'd3;
         end else if (csr_mie_i[7] && irq_timer_i) begin
            irq_take = 1'b1;
            irq_code = 4'd7;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         mip_q <= 32'd0;
      else
         mip_q <= {20'd0, irq_ext_i, 3'd0, irq_timer_i, 3'd0, irq_sw_i, 3'd0};
   end

   assign mip_o = mip_q;
`else
   assign irq_take = 1'b0;
   assign irq_code = 4'd0;
   assign mip_o    = 32'd0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (exc_valid_i || mret_i || irq_take) state_nxt = S_FLUSH;
         S_FLUSH:    state_nxt = S_WRITE;
         S_WRITE:    state_nxt = S_REDIRECT;
         S_REDIRECT: if (redirect_ready_i) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Trap context is captured only when leaving IDLE; requests while the
   // sequence runs never disturb it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_irq  <= 1'b0;
         lat_mret <= 1'b0;
         lat_code <= 4'd0;
         lat_pc   <= 32'd0;
         lat_tval <= 32'd0;
      end else if (state == S_IDLE) begin
         if (exc_valid_i) begin
            lat_irq  <= 1'b0;
            lat_mret <= 1'b0;
            lat_code <= exc_code_i;
            lat_pc   <= exc_pc_i;
            lat_tval <= exc_tval_i;
         end else if (mret_i) begin
            lat_irq  <= 1'b0;
            lat_mret <= 1'b1;
            lat_code <= 4'd0;
            lat_pc   <= 32'd0;
            lat_tval <= 32'd0;
         end else if (irq_take) begin
            lat_irq  <= 1'b1;
            lat_mret <= 1'b0;
            lat_code <= irq_code;
            lat_pc   <= next_pc_i;
            lat_tval <= 32'd0;
         end
      end
   end

   assign mtvec_base = {csr_mtvec_i[31:2], 2'b00};

   always_comb begin
      we_exc_o         = 1'b0;
      mcause_o         = 32'd0;
      mepc_o           = 32'd0;
      mtval_o          = 32'd0;
      mstatus_o        = 32'd0;
      aux_o            = 1'b0;
      stall_o          = 1'b0;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = 32'd0;
      case (state)
         S_FLUSH: begin
            stall_o = 1'b1;
            flush_o = 1'b1;
         end
         S_WRITE: begin
            stall_o  = 1'b1;
            we_exc_o = 1'b1;
            if (lat_mret) begin
               mepc_o        = csr_mepc_i;
               mcause_o      = csr_mcause_i;
               mtval_o       = csr_mtval_i;
               mstatus_o     = csr_mstatus_i;
               mstatus_o[3]  = csr_mstatus_i[7];
               mstatus_o[7]  = 1'b1;
               mstatus_o[12:11] = 2'b11;
            end else begin
               mcause_o      = {lat_irq, 27'd0, lat_code};
               mepc_o        = {lat_pc[31:2], 2'b00};
               mtval_o       = lat_tval;
               mstatus_o     = csr_mstatus_i;
               mstatus_o[7]  = csr_mstatus_i[3];
               mstatus_o[3]  = 1'b0;
               mstatus_o[12:11] = 2'b11;
            end
         end
         S_REDIRECT: begin
            stall_o          = 1'b1;
            redirect_valid_o = 1'b1;
            // For MRET the CSR file presents mepc on the mtvec input.
            aux_o            = lat_mret;
            if (!lat_mret && lat_irq && (VECTORED == 1) && (csr_mtvec_i[1:0] == 2'b01))
               redirect_pc_o = mtvec_base + {26'd0, lat_code, 2'b00};
            else
               redirect_pc_o = mtvec_base;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl
module tb_trap_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        exc_valid_i = 1'b0;
   logic [3:0]  exc_code_i = 4'd0;
   logic [31:0] exc_pc_i = 32'd0;
   logic [31:0] exc_tval_i = 32'd0;
   logic        mret_i = 1'b0;
   logic [31:0] next_pc_i = 32'd0;
   logic        irq_ext_i = 1'b0, irq_sw_i = 1'b0, irq_timer_i = 1'b0;
   logic [31:0] csr_mstatus_i = 32'd0, csr_mie_i = 32'd0, csr_mepc_i = 32'd0;
   logic [31:0] csr_mcause_i = 32'd0, csr_mtval_i = 32'd0, csr_mtvec_i = 32'd0;
   logic        we_exc_o, aux_o, stall_o, flush_o, redirect_valid_o;
   logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, redirect_pc_o, mip_o;
   logic        redirect_ready_i = 1'b0;

`ifdef TRAP_CTRL_IRQ_EN
   localparam logic [31:0] MIP_EXT = 32'h0000_0800;
`else
   localparam logic [31:0] MIP_EXT = 32'h0000_0000;
`endif

   typedef struct {
      logic [31:0] mcause, mepc, mtval, mstatus, rpc;
      logic        aux;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   trap_ctrl #(.VECTORED(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i),
      .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
      .mret_i(mret_i), .next_pc_i(next_pc_i),
      .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
      .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i), .csr_mepc_i(csr_mepc_i),
      .csr_mcause_i(csr_mcause_i), .csr_mtval_i(csr_mtval_i), .csr_mtvec_i(csr_mtvec_i),
      .we_exc_o(we_exc_o), .mcause_o(mcause_o), .mepc_o(mepc_o),
      .mtval_o(mtval_o), .mstatus_o(mstatus_o), .aux_o(aux_o),
      .stall_o(stall_o), .flush_o(flush_o),
      .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
      .redirect_ready_i(redirect_ready_i), .mip_o(mip_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] mcause, input logic [31:0] mepc,
                           input logic [31:0] mtval, input logic [31:0] mstatus,
                           input logic [31:0] rpc, input logic aux);
      exp_t e;
      e.mcause = mcause; e.mepc = mepc; e.mtval = mtval;
      e.mstatus = mstatus; e.rpc = rpc; e.aux = aux;
      exp_q.push_back(e);
   endtask

   task automatic set_csr(input logic [31:0] ms, input logic [31:0] mie,
                          input logic [31:0] mepc, input logic [31:0] mcause,
                          input logic [31:0] mtval, input logic [31:0] mtvec);
      csr_mstatus_i = ms; csr_mie_i = mie; csr_mepc_i = mepc;
      csr_mcause_i = mcause; csr_mtval_i = mtval; csr_mtvec_i = mtvec;
   endtask

   // Present the requests for exactly one IDLE cycle.
   task automatic issue(input bit exc, input bit mret, input bit ext, input bit sw, input bit tmr);
      @(posedge clk_i); #1;
      exc_valid_i = exc; mret_i = mret;
      irq_ext_i = ext; irq_sw_i = sw; irq_timer_i = tmr;
      @(posedge clk_i); #1;
      exc_valid_i = 1'b0; mret_i = 1'b0;
      irq_ext_i = 1'b0; irq_sw_i = 1'b0; irq_timer_i = 1'b0;
   endtask

   // Follows a running sequence from FLUSH back to IDLE, holding redirect
   // ready low for 'lo' REDIRECT cycles; 'noise' fires new requests while stalled.
   task automatic run_seq(input int lo, input bit noise);
      int n_flush = 0, n_we = 0, n_stall = 0, n_rv = 0;
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk_i);
         if (stall_o) n_stall++;
         if (flush_o) n_flush++;
         if (we_exc_o) n_we++;
         if (redirect_valid_o) begin
            n_rv++;
            redirect_ready_i = (n_rv > lo);
         end else begin
            redirect_ready_i = 1'b0;
         end
         if (noise && stall_o && !redirect_valid_o) begin
            exc_valid_i = 1'b1; mret_i = 1'b1;
            exc_code_i = 4'hF; exc_pc_i = 32'hFFFF_FFF0;
         end else begin
            exc_valid_i = 1'b0; mret_i = 1'b0;
         end
         if (!stall_o) done = 1'b1;
      end
      check("seq_done", {31'd0, done}, 32'd1);
      check("flush_cycles", n_flush, 32'd1);
      check("we_cycles", n_we, 32'd1);
      check("stall_cycles", n_stall, 3 + lo);
      check("redirect_cycles", n_rv, lo + 1);
   endtask

   // Scoreboard side: compare whatever the DUT emits with the queue head.
   always begin
      @(negedge clk_i); #1;
      if (we_exc_o) begin
         if (exp_q.size() == 0)
            check("we_unexpected", {31'd0, we_exc_o}, 32'd0);
         else begin
            check("mcause", mcause_o, exp_q[0].mcause);
            check("mepc", mepc_o, exp_q[0].mepc);
            check("mtval", mtval_o, exp_q[0].mtval);
            check("mstatus", mstatus_o, exp_q[0].mstatus);
         end
      end
      if (redirect_valid_o) begin
         if (exp_q.size() == 0)
            check("redirect_unexpected", {31'd0, redirect_valid_o}, 32'd0);
         else begin
            check("redirect_pc", redirect_pc_o, exp_q[0].rpc);
            check("aux", {31'd0, aux_o}, {31'd0, exp_q[0].aux});
            if (redirect_ready_i) void'(exp_q.pop_front());
         end
      end else if (aux_o) begin
         check("aux_stray", {31'd0, aux_o}, 32'd0);
      end
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_flush", {31'd0, flush_o}, 32'd0);
      check("rst_we", {31'd0, we_exc_o}, 32'd0);
      check("rst_rvalid", {31'd0, redirect_valid_o}, 32'd0);
      check("rst_mstatus", mstatus_o, 32'd0);
      check("rst_mip", mip_o, 32'd0);
      @(posedge clk_i); #1 rst_i = 1'b0;

      // basic exception
      set_csr(32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200);
      exc_code_i = 4'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
      push_exp(32'h2, 32'h100, 32'hDEAD, 32'h1880, 32'h200, 1'b0);
      issue(1, 0, 0, 0, 0);
      run_seq(0, 0);

      // misaligned pc, MIE clear, mtvec mode bits ignored for exceptions
      set_csr(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h203);
      exc_code_i = 4'hB; exc_pc_i = 32'h103; exc_tval_i = 32'h1234_5678;
      push_exp(32'hB, 32'h100, 32'h1234_5678, 32'h1800, 32'h200, 1'b0);
      issue(1, 0, 0, 0, 0);
      run_seq(1, 1);

      // MRET with MPIE=1
      set_csr(32'h1880, 32'h0, 32'h104, 32'h55, 32'h77, 32'h104);
      push_exp(32'h55, 32'h104, 32'h77, 32'h1888, 32'h104, 1'b1);
      issue(0, 1, 0, 0, 0);
      run_seq(0, 0);

      // MRET with MPIE=0
      set_csr(32'h0, 32'h0, 32'h2000, 32'h3, 32'h9, 32'h2000);
      push_exp(32'h3, 32'h2000, 32'h9, 32'h1880, 32'h2000, 1'b1);
      issue(0, 1, 0, 0, 0);
      run_seq(2, 0);

      // exception, MRET and ext interrupt together; redirect held 4 cycles
      set_csr(32'h8, 32'h800, 32'h0, 32'h0, 32'h0, 32'h400);
      exc_code_i = 4'd5; exc_pc_i = 32'h2000; exc_tval_i = 32'h11;
      push_exp(32'h5, 32'h2000, 32'h11, 32'h1880, 32'h400, 1'b0);
      issue(1, 1, 1, 0, 0);
      run_seq(3, 1);
      repeat (3) @(negedge clk_i);
      check("no_second_seq", {31'd0, stall_o}, 32'd0);

`ifdef TRAP_CTRL_IRQ_EN
      // vectored timer interrupt
      set_csr(32'h8, 32'h80, 32'h0, 32'h0, 32'h0, 32'h301);
      next_pc_i = 32'h40;
      push_exp(32'h8000_0007, 32'h40, 32'h0, 32'h1880, 32'h31C, 1'b0);
      issue(0, 0, 0, 0, 1);
      run_seq(0, 0);

      // ext beats sw and timer
      set_csr(32'h8, 32'h888, 32'h0, 32'h0, 32'h0, 32'h301);
      next_pc_i = 32'h86;
      push_exp(32'h8000_000B, 32'h84, 32'h0, 32'h1880, 32'h32C, 1'b0);
      issue(0, 0, 1, 1, 1);
      run_seq(1, 0);
`endif

      // interrupt lines with global MIE off: never a sequence
      set_csr(32'h0, 32'h888, 32'h0, 32'h0, 32'h0, 32'h301);
      @(posedge clk_i); #1 irq_ext_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("masked_irq_stall", {31'd0, stall_o}, 32'd0);
      end
      check("mip_mirror", mip_o, MIP_EXT);

      // MIE on but build may lack interrupt support
`ifndef TRAP_CTRL_IRQ_EN
      csr_mstatus_i = 32'h8;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         check("noirq_stall", {31'd0, stall_o}, 32'd0);
      end
      check("noirq_mip", mip_o, 32'd0);
`endif
      @(posedge clk_i); #1 irq_ext_i = 1'b0;
      @(posedge clk_i);

      // reset while in WRITE aborts the sequence
      set_csr(32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200);
      exc_code_i = 4'd1; exc_pc_i = 32'h500; exc_tval_i = 32'h0;
      push_exp(32'h1, 32'h500, 32'h0, 32'h1880, 32'h200, 1'b0);
      issue(1, 0, 0, 0, 0);
      @(posedge clk_i); #1 rst_i = 1'b1;
      @(negedge clk_i);
      check("write_before_rst", {31'd0, we_exc_o}, 32'd1);
      @(posedge clk_i); #1 rst_i = 1'b0;
      exp_q.delete();
      @(negedge clk_i);
      check("rst_mid_we", {31'd0, we_exc_o}, 32'd0);
      check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
      check("rst_mid_rvalid", {31'd0, redirect_valid_o}, 32'd0);

      // clean sequence after mid-sequence reset
      set_csr(32'h1880, 32'h0, 32'h104, 32'h2, 32'h0, 32'h104);
      push_exp(32'h2, 32'h104, 32'h0, 32'h1888, 32'h104, 1'b1);
      issue(0, 1, 0, 0, 0);
      run_seq(0, 0);

      repeat (2) @(negedge clk_i);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter: VECTORED, 0, 1 enables mtvec vectored mode (mtvec[1:0]==01) for interrupts.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: exc_valid_i  input  1; exc_code_i  input  4; exc_pc_i  input  32; exc_tval_i  input  32 — synchronous exception request and its data.
REQ-005 SHALL have ports: mret_i  input  1  MRET retiring; next_pc_i  input  32  PC of next unretired instruction (interrupt mepc).
REQ-006 SHALL have ports: irq_ext_i, irq_sw_i, irq_timer_i  input  1 each  level interrupt lines.
REQ-007 SHALL have ports: csr_mstatus_i, csr_mie_i, csr_mepc_i, csr_mcause_i, csr_mtval_i, csr_mtvec_i  input  32 each  current CSR values; csr_mtvec_i carries mepc while aux_o=1.
REQ-008 SHALL have ports: we_exc_o  output  1; mcause_o, mepc_o, mtval_o, mstatus_o  output  32 each; aux_o  output  1 — CSR trap write bus.
REQ-009 SHALL have ports: stall_o, flush_o  output  1 each; redirect_valid_o  output  1; redirect_pc_o  output  32; redirect_ready_i  input  1; mip_o  output  32  pending-interrupt mirror.

Function
REQ-010 SHALL implement FSM IDLE -> FLUSH -> WRITE -> REDIRECT -> IDLE, one cycle per state except REDIRECT.
REQ-011 SHALL, in IDLE, start on (priority) exc_valid_i > mret_i > qualified interrupt; lower-priority requests that cycle are dropped.
REQ-012 SHALL qualify an interrupt as csr_mstatus_i[3] && csr_mie_i[n] && line n; priority ext(11) > sw(3) > timer(7).
REQ-013 SHALL latch kind, code, pc (exc_pc_i for exceptions, next_pc_i for interrupts) and tval (exc_tval_i; 0 for interrupts) on leaving IDLE.
REQ-014 SHALL assert stall_o in FLUSH, WRITE, REDIRECT; flush_o only in FLUSH.
REQ-015 SHALL assert we_exc_o for exactly one cycle, in WRITE.
REQ-016 SHALL, on trap in WRITE, drive mcause_o={is_irq,27'b0,code}, mepc_o=latched pc with bits[1:0] cleared, mtval_o=latched tval, mstatus_o=csr_mstatus_i with MPIE(7)=MIE(3), MIE=0, MPP[12:11]=11.
REQ-017 SHALL, on MRET in WRITE, drive mepc_o=csr_mepc_i, mcause_o=csr_mcause_i, mtval_o=csr_mtval_i, mstatus_o with MIE=MPIE, MPIE=1, MPP=11.
REQ-018 SHALL drive redirect_pc_o in REDIRECT: trap -> {csr_mtvec_i[31:2],2'b00}, plus 4*code when VECTORED=1, interrupt and csr_mtvec_i[1:0]==01; MRET -> {csr_mtvec_i[31:2],2'b00} with aux_o=1.
REQ-019 SHALL assert aux_o only in REDIRECT of an MRET sequence.
REQ-020 SHALL hold REDIRECT with redirect_valid_o=1 and stable redirect_pc_o until redirect_ready_i=1; return to IDLE next edge.
REQ-021 SHALL ignore exc_valid_i, mret_i and interrupts outside IDLE (pipeline stalled).
REQ-022 SHALL drive mip_o bits 11/7/3 = registered irq_ext_i/irq_timer_i/irq_sw_i, all other bits 0.
REQ-023 SHALL drive all outputs 0 in IDLE except mip_o.

Reset
REQ-024 SHALL, with rst_i high at a rising edge, enter IDLE from any state (including mid-sequence, no CSR write issued) and clear all outputs and latches to 0 at that edge.

Configuration
REQ-025 SHALL, with TRAP_CTRL_IRQ_EN defined, implement interrupt qualification, vectoring and mip_o as above.
REQ-026 SHALL, without TRAP_CTRL_IRQ_EN, ignore irq_* lines, tie mip_o to 0, and handle only exceptions and MRET.

Verification
REQ-027 SHALL cover: exc_valid_i=1, code=2, pc=0x100, tval=0xDEAD, mstatus=0x8, mtvec=0x200 -> WRITE: mcause=0x2, mepc=0x100, mtval=0xDEAD, mstatus=0x1880; redirect_pc=0x200.
REQ-028 SHALL cover: MIE=1, mie[7]=1, irq_timer_i=1, next_pc=0x40, mtvec=0x301, VECTORED=1 -> mcause=0x80000007, mepc=0x40, mtval=0, redirect_pc=0x31C.
REQ-029 SHALL cover: mret_i=1, mstatus=0x1880, mepc=0x104 (via aux_o) -> mstatus_o=0x1888, aux_o=1, redirect_pc=0x104.
REQ-030 SHALL cover: exc_valid_i, mret_i, irq_ext_i same cycle -> exception sequence only; redirect_ready_i low 3 cycles -> REDIRECT held 4 cycles, pc stable.
REQ-031 SHALL cover: rst_i high in WRITE -> we_exc_o=0 next cycle, IDLE; build without TRAP_CTRL_IRQ_EN, irq_ext_i=1 -> no sequence, mip_o=0.
